lfsr_crack_depad: RTL and testbench

Streaming hardware successor to the software decrypt/depad program. Consumes LFSR-encrypted, parity-tagged characters from memory, self-identifies the LFSR seed and tap pattern from the space preamble, decrypts, strips leading spaces, flags parity errors, and emits a fixed-length output stream. Sits between the data-memory read port and the result write port; runs under the top-level `req`/`ack` handshake.

---
 rtl/lfsr_crack_depad.sv | 224 ++++++++++++++++++++++
 tb/tb_lfsr_crack_depad.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_crack_depad.sv
// rtl/lfsr_crack_depad.sv - LFSR seed/tap cracker, decryptor and leading-space stripper
//
// Consumes LEN parity-tagged encrypted characters per run. The first char is
// an encrypted space, so its payload is the LFSR seed. The next TRAIN chars
// eliminate candidate tap patterns, and the lowest surviving pattern decrypts
// the rest of the stream. Leading spaces are dropped and the output is
// zero-padded so that exactly LEN words leave per run.
//
// Optional feature macro: LFSR_PARITY_CHECK_EN. When it is defined, parity
// errors are flagged in out_data[W], parity-failed training chars do not
// eliminate candidates, and parity-failed leading chars are never dropped.
// When it is undefined, every char is treated as parity-clean.
//
// Ports:
//   clk, init                      clock, synchronous active-high reset
//   req, ack                       run start (sampled when idle), run complete (held)
//   err                            no candidate survived training (valid with ack)
//   ptrn_idx                       selected tap pattern index (valid with ack)
//   in_valid, in_ready, in_data    encrypted char stream, MSB is the parity bit
//   out_valid, out_ready, out_data {parity_err, plain}, plain 0 means a space

module lfsr_crack_depad #(
    parameter int                 W     = 7,
    parameter int                 NPTRN = 9,
    parameter logic [NPTRN*W-1:0] PTRNS = {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A,
                                           7'h72, 7'h78, 7'h48, 7'h60},
    parameter int                 TRAIN = 8,
    parameter int                 LEN   = 64
) (
    input  logic                       clk,
    input  logic                       init,
    input  logic                       req,
    output logic                       ack,
    output logic                       err,
    output logic [$clog2(NPTRN)-1:0]   ptrn_idx,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W:0]                 in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W:0]                 out_data
);

    localparam int IW = $clog2(NPTRN);
    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_TRAIN, S_LEAD, S_BODY, S_PAD, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]     lfsr     [NPTRN];
    logic [W-1:0]     lfsr_adv [NPTRN];
    logic [NPTRN-1:0] live;
    logic [NPTRN-1:0] live_nx;
    logic [NPTRN-1:0] mismatch;
    logic [CW-1:0]    in_cnt;
    logic [CW-1:0]    out_cnt;

    logic [W-1:0]  payload;
    logic          perr;
    logic [W-1:0]  key_sel;
    logic [W-1:0]  plain;
    logic [IW-1:0] first_live;
    logic          any_live;
    logic          accept;
    logic          load;
    logic [W:0]    load_data;
    logic          out_free;
    logic          in_left;
    logic          out_left;
    logic          train_last;

    assign payload = in_data[W-1:0];

`ifdef LFSR_PARITY_CHECK_EN
    assign perr = in_data[W] ^ (^in_data[W-1:0]);
`else
    logic unused_parity;
    assign unused_parity = in_data[W];
    assign perr          = 1'b0;
`endif

    // Every candidate steps in lockstep; only the selected one matters after training.
    always_comb begin
        for (int i = 0; i < NPTRN; i++) begin
            lfsr_adv[i] = {lfsr[i][W-2:0], ^(lfsr[i] & PTRNS[i*W +: W])};
            mismatch[i] = (lfsr_adv[i] != payload);
        end
    end

    // A parity-failed training char says nothing reliable, so it cannot eliminate.
    assign live_nx  = perr ? live : (live & ~mismatch);
    assign any_live = |live_nx;

    always_comb begin
        first_live = '0;
        for (int i = NPTRN - 1; i >= 0; i--) begin
            if (live_nx[i]) first_live = IW'(i);
        end
    end

    always_comb begin
        key_sel = '0;
        for (int i = 0; i < NPTRN; i++) begin
            if (ptrn_idx == IW'(i)) key_sel = lfsr_adv[i];
        end
    end

    assign plain      = payload ^ key_sel;
    assign out_free   = !out_valid || out_ready;
    assign in_left    = (in_cnt != CW'(LEN));
    assign out_left   = (out_cnt != CW'(LEN));
    assign train_last = (in_cnt == CW'(TRAIN));
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        load_data = {perr, plain};
        case (state)
            S_IDLE, S_DONE: begin
                if (req) state_nx = S_SEED;
            end
            S_SEED: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_TRAIN;
            end
            S_TRAIN: begin
                in_ready = 1'b1;
                if (in_valid && train_last) state_nx = any_live ? S_LEAD : S_DONE;
            end
            S_LEAD: begin
                if (!in_left) begin
                    state_nx = S_PAD;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (plain == '0 && !perr) begin
                            if (in_cnt == CW'(LEN - 1)) state_nx = S_PAD;
                        end else begin
                            load     = 1'b1;
                            state_nx = S_BODY;
                        end
                    end
                end
            end
            S_BODY: begin
                // Output budget exhausted: finish once the last word drains.
                if (!out_left) begin
                    if (out_free) state_nx = S_DONE;
                end else if (!in_left) begin
                    state_nx = S_PAD;
                end else begin
                    in_ready = out_free;
                    load     = in_valid && out_free;
                end
            end
            S_PAD: begin
                load_data = '0;
                if (!out_left) begin
                    if (out_free) state_nx = S_DONE;
                end else begin
                    load = out_free;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state     <= S_IDLE;
            ack       <= 1'b0;
            err       <= 1'b0;
            ptrn_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            live      <= '1;
            in_cnt    <= '0;
            out_cnt   <= '0;
            for (int i = 0; i < NPTRN; i++) lfsr[i] <= '0;
        end else begin
            state <= state_nx;

            if ((state == S_IDLE || state == S_DONE) && req) begin
                in_cnt   <= '0;
                out_cnt  <= '0;
                live     <= '1;
                ack      <= 1'b0;
                err      <= 1'b0;
                ptrn_idx <= '0;
            end

            if (accept) begin
                in_cnt <= in_cnt + 1'b1;
                for (int i = 0; i < NPTRN; i++) begin
                    lfsr[i] <= (state == S_SEED) ? payload : lfsr_adv[i];
                end
            end

            if (accept && state == S_TRAIN) begin
                live <= live_nx;
                if (train_last) begin
                    if (any_live) ptrn_idx <= first_live;
                    else          err      <= 1'b1;
                end
            end

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_cnt   <= out_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state_nx == S_DONE && state != S_DONE) ack <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lfsr_crack_depad.sv
// tb/tb_lfsr_crack_depad.sv - self-checking bench for lfsr_crack_depad
module tb_lfsr_crack_depad;

    localparam int W     = 7;
    localparam int NPTRN = 9;
    localparam int TRAIN = 8;
    localparam int LEN   = 64;

    logic       clk = 1'b0;
    logic       init, req, in_valid, out_ready;
    logic [7:0] in_data;
    logic       ack, err, in_ready, out_valid;
    logic [3:0] ptrn_idx;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    lfsr_crack_depad dut (
        .clk(clk), .init(init), .req(req), .ack(ack), .err(err),
        .ptrn_idx(ptrn_idx), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    logic [6:0] ptv [NPTRN] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    logic [7:0] enc    [LEN];
    logic [6:0] pl_txt [LEN];
    logic [7:0] got    [LEN];
    logic [7:0] exp_w  [LEN];
    int         n_got, exp_n, exp_idx_m;
    bit         exp_err_m, saw_ov;
    int         n_chk = 0;
    int         n_pass = 0;
    string      msg0 = "Mr. Watson, come here. I want to see you.";
    string      msg1 = "   Ajok";

`ifdef LFSR_PARITY_CHECK_EN
    localparam logic [7:0] FLIPW = 8'hCD;
`else
    localparam logic [7:0] FLIPW = 8'h4D;
`endif

    typedef struct {
        int         pi;
        logic [6:0] seed;
        int         pre;
        int         msg;
        int         fpos;
        int         fbit;
        int         rmode;
        int         exp_idx;
        bit         exp_err;
        int         cpos;
        logic [7:0] cword;
    } vec_t;

    vec_t vt [5];

    task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got_v, exp_v);
    endtask

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    function automatic logic [6:0] key_at(input logic [6:0] p, input logic [6:0] sd, input int k);
        logic [6:0] s;
        s = sd;
        for (int j = 0; j < k; j++) s = step(s, p);
        return s;
    endfunction

    function automatic bit perr_of(input logic [7:0] c);
`ifdef LFSR_PARITY_CHECK_EN
        return c[7] ^ (^c[6:0]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_plain(input int pre, input string m);
        logic [7:0] c;
        for (int k = 0; k < LEN; k++) begin
            pl_txt[k] = '0;
            if (k >= pre && (k - pre) < m.len()) begin
                c = m[k-pre];
                pl_txt[k] = 7'(c - 8'h20);
            end
        end
    endtask

    task automatic encrypt(input int pi, input logic [6:0] seed, input int fpos, input int fbit);
        logic [6:0] s, pay;
        s = seed;
        for (int k = 0; k < LEN; k++) begin
            pay    = pl_txt[k] ^ s;
            enc[k] = {^pay, pay};
            s      = step(s, ptv[pi]);
        end
        if (fpos >= 0) enc[fpos][fbit] = ~enc[fpos][fbit];
    endtask

    task automatic random_train(input logic [6:0] seed);
        logic [6:0] pay;
        enc[0] = {^seed, seed};
        for (int k = 1; k < LEN; k++) begin
            pay    = 7'($urandom);
            enc[k] = {^pay, pay};
        end
    endtask

    // Reference: survivors of training, then decrypt/strip/pad from the stored stream.
    task automatic model();
        logic [NPTRN-1:0] lv;
        logic [6:0]       sd, pl;
        int               sel, j;
        bit               lead, pe;
        sd = enc[0][6:0];
        lv = '1;
        for (int i = 0; i < NPTRN; i++)
            for (int k = 1; k <= TRAIN; k++)
                if (!perr_of(enc[k]) && key_at(ptv[i], sd, k) != enc[k][6:0]) lv[i] = 1'b0;
        exp_err_m = (lv == '0);
        sel = 0;
        for (int i = NPTRN - 1; i >= 0; i--) if (lv[i]) sel = i;
        exp_idx_m = sel;
        for (int k = 0; k < LEN; k++) exp_w[k] = '0;
        exp_n = exp_err_m ? 0 : LEN;
        if (!exp_err_m) begin
            lead = 1'b1;
            j    = 0;
            for (int k = TRAIN + 1; k < LEN; k++) begin
                pl = enc[k][6:0] ^ key_at(ptv[sel], sd, k);
                pe = perr_of(enc[k]);
                if (!(lead && pl == '0 && !pe)) begin
                    lead = 1'b0;
                    if (j < LEN) exp_w[j] = {pe, pl};
                    j++;
                end
            end
        end
    endtask

    task automatic check_stream(input string nm);
        int bad, fb;
        bad = 0;
        fb  = -1;
        check({nm, "_count"}, n_got, exp_n);
        for (int j = 0; j < exp_n && j < n_got && j < LEN; j++) begin
            if (got[j] !== exp_w[j]) begin
                if (fb < 0) fb = j;
                bad++;
            end
        end
        if (fb >= 0) $display("  %s first differing word %0d: got %h want %h", nm, fb, got[fb], exp_w[fb]);
        check({nm, "_words"}, bad, 0);
    endtask

    task automatic run_dut(input int rmode, input int init_at, input bit chk_tm);
        int in_idx, cyc, acc_cyc, viol;
        bit done;
        in_idx = 0; cyc = 0; acc_cyc = -1; viol = 0; done = 1'b0;
        saw_ov = 1'b0; n_got = 0;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        while (!done && cyc < 4000) begin
            in_valid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = (in_idx < LEN) ? enc[in_idx] : 8'h00;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 2) == 1);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            req = (rmode == 2) && !ack && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (out_valid && !out_ready && in_ready) viol++;
            if (out_valid) saw_ov = 1'b1;
            if (chk_tm && acc_cyc >= 0 && cyc == acc_cyc + 1) begin
                check("err_ack_timing", ack, 1);
                check("err_flag_timing", err, 1);
            end
            if (ack) done = 1'b1;
            if (in_valid && in_ready) begin
                in_idx++;
                if (chk_tm && in_idx == TRAIN + 1) begin
                    acc_cyc = cyc;
                    check("ack_before_last_train", ack, 0);
                end
            end
            if (out_valid && out_ready) begin
                if (n_got < LEN) got[n_got] = out_data;
                n_got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (init_at >= 0 && n_got == init_at) begin
                init = 1'b1; in_valid = 1'b0; out_ready = 1'b0; req = 1'b0;
                @(posedge clk); #1;
                init = 1'b0;
                done = 1'b1;
            end
        end
        check("run_done", done, 1);
        check("in_ready_stall", viol, 0);
        in_valid = 1'b0; out_ready = 1'b0; req = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_idx"}, ptrn_idx, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin : main
        int         pre, len, pi, fpos;
        logic [6:0] seed;
        bit         any_rdy;

        vt[0] = '{0, 7'h01, 10, 0, -1, 0, 0, 0, 1'b0, 0,  8'h2D};
        vt[1] = '{8, 7'h55, 15, 0, -1, 0, 2, 8, 1'b0, 1,  8'h52};
        vt[2] = '{0, 7'h01, 10, 0, 30, 3, 1, 0, 1'b0, 20, FLIPW};
        vt[3] = '{0, 7'h01, 10, 1, -1, 0, 2, 0, 1'b0, 0,  8'h21};
        vt[4] = '{0, 7'h33, 0,  2, -1, 0, 0, 0, 1'b1, 0,  8'h00};

        init = 1'b1; req = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 init = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            if (vt[v].msg == 2) random_train(vt[v].seed);
            else begin
                set_plain(vt[v].pre, (vt[v].msg == 0) ? msg0 : msg1);
                encrypt(vt[v].pi, vt[v].seed, vt[v].fpos, vt[v].fbit);
            end
            model();
            run_dut(vt[v].rmode, -1, vt[v].exp_err);
            @(negedge clk);
            check($sformatf("vec%0d_err", v), err, vt[v].exp_err);
            if (vt[v].exp_err) begin
                check($sformatf("vec%0d_no_out_valid", v), saw_ov, 0);
            end else begin
                check($sformatf("vec%0d_idx", v), ptrn_idx, vt[v].exp_idx);
                check($sformatf("vec%0d_word%0d", v, vt[v].cpos),
                      (n_got > vt[v].cpos) ? got[vt[v].cpos] : 8'hXX, vt[v].cword);
            end
            check_stream($sformatf("vec%0d_stream", v));
            @(posedge clk); #1;
        end

        // init mid-run while out_ready toggles, then a clean rerun
        set_plain(10, msg0);
        encrypt(0, 7'h01, -1, 0);
        model();
        run_dut(1, 12, 1'b0);
        exp_n = 12;
        check_stream("pre_init_stream");
        any_rdy = 1'b0;
        in_valid = 1'b1;
        in_data  = enc[0];
        repeat (4) begin
            @(negedge clk);
            any_rdy |= in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("post_init_no_ready", any_rdy, 0);
        check_reset_vals("post_init");
        @(posedge clk); #1;
        model();
        run_dut(0, -1, 1'b0);
        @(negedge clk);
        check("rerun_idx", ptrn_idx, 0);
        check("rerun_err", err, 0);
        check_stream("rerun_stream");
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) begin
            pi   = $urandom_range(0, NPTRN - 1);
            seed = 7'($urandom);
            pre  = $urandom_range(TRAIN + 1, 16);
            len  = $urandom_range(1, 30);
            for (int k = 0; k < LEN; k++) begin
                pl_txt[k] = '0;
                if (k >= pre && k < pre + len && $urandom_range(0, 7) != 0)
                    pl_txt[k] = 7'($urandom_range(8'h21, 8'h7E) - 8'h20);
            end
            fpos = ($urandom_range(0, 1) == 1) ? $urandom_range(0, LEN - 1) : -1;
            encrypt(pi, seed, fpos, $urandom_range(0, 6));
            model();
            run_dut(2, -1, 1'b0);
            @(negedge clk);
            check($sformatf("rnd%0d_err", r), err, exp_err_m);
            if (!exp_err_m) check($sformatf("rnd%0d_idx", r), ptrn_idx, exp_idx_m);
            check_stream($sformatf("rnd%0d_stream", r));
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
